// File: rtl/cacheline_pkg.sv
// Shared widths, FSM state type and address helper for the cache-line
// to burst-memory adapter.
package cacheline_pkg;
  localparam int s_line   = 256;
  localparam int s_burst  = 64;
  localparam int s_beats  = s_line / s_burst;
  localparam int s_offset = 5;
  localparam int s_cnt_w  = $clog2(s_beats);

  typedef logic [s_cnt_w-1:0] beat_t;
  localparam beat_t last_beat = beat_t'(s_beats - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adapter_state_t;

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:s_offset], {s_offset{1'b0}}};
  endfunction
endpackage

// File: rtl/cacheline_adapter_if.sv
// Cache-side line port and memory-side burst port of the adapter.
interface cacheline_adapter_if;
  import cacheline_pkg::*;

  logic [31:0]        pmem_address;
  logic               pmem_read;
  logic               pmem_write;
  logic [s_line-1:0]  pmem_wdata;
  logic [s_line-1:0]  pmem_rdata;
  logic               pmem_resp;

  logic [31:0]        mem_address;
  logic               mem_read;
  logic               mem_write;
  logic [s_burst-1:0] mem_wdata;
  logic [s_burst-1:0] mem_rdata;
  logic               mem_resp;

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata, mem_rdata, mem_resp,
    output pmem_rdata, pmem_resp, mem_address, mem_read, mem_write, mem_wdata
  );

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata, mem_rdata, mem_resp,
    input  pmem_rdata, pmem_resp, mem_address, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/line_buffer.sv
// One cache line held as beats: full-line load, per-beat write, per-beat read.
module line_buffer
  import cacheline_pkg::*;
#(
  parameter int DATA_W = s_burst
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [s_beats*DATA_W-1:0] load_data,
  input  logic                      beat_we,
  input  beat_t                     beat_idx,
  input  logic [DATA_W-1:0]         beat_data,
  output logic [DATA_W-1:0]         beat_out,
  output logic [s_beats*DATA_W-1:0] line
);
  logic [s_beats-1:0][DATA_W-1:0] buf_q;

  // Full-line load takes priority; the FSM never asserts both together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (load) begin
      buf_q <= load_data;
    end else if (beat_we) begin
      buf_q[beat_idx] <= beat_data;
    end
  end

  assign beat_out = buf_q[beat_idx];
  assign line     = buf_q;
endmodule

// File: rtl/cacheline_adapter.sv
// Turns one 256-bit line read/write from the cache into a 4-beat 64-bit
// burst to memory; read beats are assembled into a line buffer.
module cacheline_adapter
  import cacheline_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  cacheline_adapter_if.slave  bus
);
  adapter_state_t state_q, state_d;
  beat_t          cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic           wbuf_load;
  logic           rbuf_store;

  logic [s_burst-1:0] rbuf_beat_unused;
  logic [s_line-1:0]  wbuf_line_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Write request wins over read when both arrive together.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wbuf_load  = 1'b0;
    rbuf_store = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pmem_write) begin
          state_d   = WRITE;
          addr_d    = line_align(bus.pmem_address);
          cnt_d     = '0;
          wbuf_load = 1'b1;
        end else if (bus.pmem_read) begin
          state_d = READ;
          addr_d  = line_align(bus.pmem_address);
          cnt_d   = '0;
        end
      end
      READ: begin
        if (bus.mem_resp) begin
          rbuf_store = 1'b1;
          cnt_d      = cnt_q + beat_t'(1);
          if (cnt_q == last_beat) state_d = DONE;
        end
      end
      WRITE: begin
        if (bus.mem_resp) begin
          cnt_d = cnt_q + beat_t'(1);
          if (cnt_q == last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus controls come from registered state only.
  assign bus.mem_read    = (state_q == READ);
  assign bus.mem_write   = (state_q == WRITE);
  assign bus.pmem_resp   = (state_q == DONE);
  assign bus.mem_address = addr_q;

  line_buffer #(.DATA_W(s_burst)) u_rbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (1'b0),
    .load_data ('0),
    .beat_we   (rbuf_store),
    .beat_idx  (cnt_q),
    .beat_data (bus.mem_rdata),
    .beat_out  (rbuf_beat_unused),
    .line      (bus.pmem_rdata)
  );

  line_buffer #(.DATA_W(s_burst)) u_wbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (wbuf_load),
    .load_data (bus.pmem_wdata),
    .beat_we   (1'b0),
    .beat_idx  (cnt_q),
    .beat_data ('0),
    .beat_out  (bus.mem_wdata),
    .line      (wbuf_line_unused)
  );
endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: reads, writes, stalls, priority,
// mid-burst reset and idle mem_resp noise.
module tb_cacheline_adapter;
  import cacheline_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cacheline_adapter_if bus();

  cacheline_adapter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int lat;
  logic [63:0] rbeats [4];

  localparam logic [255:0] line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] line_w = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [255:0] line_c = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                     64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0};
  localparam logic [255:0] line_d = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                     64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beats(input logic [255:0] l);
    for (int i = 0; i < 4; i++) rbeats[i] = l[64*i +: 64];
  endtask

  // Issues one line request at the current cycle and services the burst
  // with mem_resp following pat (LSB first; 1 once the pattern runs out).
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] exp_addr, input logic [255:0] wline,
                      input logic [15:0] pat, input int plen, output int cyc);
    int k;
    int idx;
    logic r;
    bus.pmem_read    = rd;
    bus.pmem_write   = wr;
    bus.pmem_address = a;
    bus.pmem_wdata   = wline;
    cycle();
    cyc = 1;
    k   = 0;
    idx = 0;
    while (bus.pmem_resp !== 1'b1 && cyc < 40) begin
      r = (idx < plen) ? pat[idx] : 1'b1;
      idx++;
      chk("mem_read", bus.mem_read, rd & ~wr);
      chk("mem_write", bus.mem_write, wr);
      chk("mem_address", bus.mem_address, exp_addr);
      if (wr) chk("mem_wdata", bus.mem_wdata, wline[64*(k & 3) +: 64]);
      bus.mem_resp  = r;
      bus.mem_rdata = r ? rbeats[k & 3] : 64'hDEAD_BEEF_DEAD_BEEF;
      cycle();
      cyc++;
      if (r) k++;
    end
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    chk("pmem_resp_seen", bus.pmem_resp, 1'b1);
    chk("done_mem_read", bus.mem_read, 1'b0);
    chk("done_mem_write", bus.mem_write, 1'b0);
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    cycle();
    chk("pmem_resp_one_cycle", bus.pmem_resp, 1'b0);
  endtask

  initial begin
    bus.pmem_address = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_wdata   = '0;
    bus.mem_rdata    = '0;
    bus.mem_resp     = 1'b0;

    cycle();
    chk("rst_pmem_resp", bus.pmem_resp, 1'b0);
    chk("rst_mem_read", bus.mem_read, 1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_mem_address", bus.mem_address, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 64'h0);
    chk("rst_pmem_rdata", bus.pmem_rdata, 256'h0);
    rst_n = 1'b1;
    cycle();

    // Back-to-back read
    set_beats(line_a);
    xfer(1'b1, 1'b0, 32'h0000_1234, 32'h0000_1220, '0, 16'hFFFF, 0, lat);
    chk("read_latency", lat, 5);
    chk("read_line", bus.pmem_rdata, line_a);

    // Write keeps the read line intact
    xfer(1'b0, 1'b1, 32'h0000_8008, 32'h0000_8000, line_w, 16'hFFFF, 0, lat);
    chk("write_latency", lat, 5);
    chk("rdata_after_write", bus.pmem_rdata, line_a);

    // Read with mem_resp gaps 1,0,0,1,1,0,1
    set_beats(line_a);
    xfer(1'b1, 1'b0, 32'h0000_1234, 32'h0000_1220, '0, 16'b101_1001, 7, lat);
    chk("gap_latency", lat, 8);
    chk("gap_line", bus.pmem_rdata, line_a);

    // Both requests high: write only
    xfer(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0, line_c, 16'hFFFF, 0, lat);
    chk("both_latency", lat, 5);
    chk("rdata_after_both", bus.pmem_rdata, line_a);

    // mem_resp noise while idle
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 64'h1234_5678_9ABC_DEF0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("idle_pmem_resp", bus.pmem_resp, 1'b0);
      chk("idle_mem_read", bus.mem_read, 1'b0);
      chk("idle_mem_write", bus.mem_write, 1'b0);
    end
    bus.mem_resp = 1'b0;
    chk("idle_rdata", bus.pmem_rdata, line_a);

    // Reset during beat 2 of a read
    set_beats(line_d);
    bus.pmem_read    = 1'b1;
    bus.pmem_address = 32'h4000_0047;
    cycle();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = rbeats[0];
    cycle();
    bus.mem_rdata = rbeats[1];
    cycle();
    bus.mem_rdata = rbeats[2];
    chk("midburst_mem_read", bus.mem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_read", bus.mem_read, 1'b0);
    chk("async_rst_mem_write", bus.mem_write, 1'b0);
    chk("async_rst_pmem_resp", bus.pmem_resp, 1'b0);
    chk("async_rst_rdata", bus.pmem_rdata, 256'h0);
    bus.pmem_read = 1'b0;
    bus.mem_resp  = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_rst_pmem_resp", bus.pmem_resp, 1'b0);
    end

    // Next read restarts at beat 0
    xfer(1'b1, 1'b0, 32'h4000_0047, 32'h4000_0040, '0, 16'hFFFF, 0, lat);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_line", bus.pmem_rdata, line_d);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
